booth_mul_seq: RTL and testbench

Sequential radix-2 Booth multiplier that sits beside the 8-bit `DataPath` register file. It consumes two signed operands read from the registers, such as `read_data1` of R1. It returns the 2·WIDTH-bit product through a two-beat write-back port, low byte then high byte, shaped like `write_enable1`/`write_data1` so it can feed the register write port directly.

---
 rtl/mul_pkg.sv | 16 +
 rtl/booth_step.sv | 29 ++
 rtl/booth_mul_seq.sv | 109 ++++++++++
 tb/tb_booth_mul_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 8;

  localparam logic WB_SEL_LO = 1'b0;
  localparam logic WB_SEL_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub select then arithmetic shift.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_nx,
  output logic [WIDTH-1:0] q_nx,
  output logic             q_m1_nx
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    unique case (1'b1)
      (q[0] & ~q_m1): sum = a - m;
      (~q[0] & q_m1): sum = a + m;
      default:        sum = a;
    endcase
  end

  assign a_nx    = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nx    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_nx = q[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with a two-beat write-back port.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic             wb_enable,
  output logic             wb_sel,
  output logic [WIDTH-1:0] wb_data
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_nx;

  logic [WIDTH:0]   a_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   a_nx;
  logic [WIDTH-1:0] q_nx;
  logic             qm1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .q      (q_q),
    .q_m1   (qm1_q),
    .m      (m_q),
    .a_nx   (a_nx),
    .q_nx   (q_nx),
    .q_m1_nx(qm1_nx)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      a_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            m_q   <= {multiplicand[WIDTH-1], multiplicand};
            a_q   <= '0;
            q_q   <= multiplier;
            qm1_q <= 1'b0;
            cnt_q <= CW'(WIDTH);
          end
        end
        STEP: begin
          a_q   <= a_nx;
          q_q   <= q_nx;
          qm1_q <= qm1_nx;
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = STEP;
      STEP:    if (cnt_q == CW'(1)) state_nx = WB_LO;
      WB_LO:   state_nx = WB_HI;
      WB_HI:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs depend only on the state and datapath registers.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    wb_enable = 1'b0;
    wb_sel    = WB_SEL_LO;
    wb_data   = '0;
    case (state)
      STEP: busy = 1'b1;
      WB_LO: begin
        busy      = 1'b1;
        wb_enable = 1'b1;
        wb_data   = q_q;
      end
      WB_HI: begin
        busy      = 1'b1;
        done      = 1'b1;
        wb_enable = 1'b1;
        wb_sel    = WB_SEL_HI;
        wb_data   = a_q[WIDTH-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and random checks of booth_mul_seq against integer multiplication.
module tb_booth_mul_seq;

  logic       clk;
  logic       clear;
  logic       start;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic       busy;
  logic       done;
  logic       wb_enable;
  logic       wb_sel;
  logic [7:0] wb_data;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.WIDTH(8)) dut (
    .clock       (clk),
    .clear       (clear),
    .start       (start),
    .multiplicand(mcand),
    .multiplier  (mplier),
    .busy        (busy),
    .done        (done),
    .wb_enable   (wb_enable),
    .wb_sel      (wb_sel),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    start  = 1'b1;
    mcand  = m;
    mplier = q;
  endtask

  // Accepts at the next posedge, then checks cycles E0+1..E0+11.
  // With lock, start stays high with churning operands, and the
  // pair nm/nq is presented for acceptance at E0+11.
  task automatic finish(input logic [7:0] m, input logic [7:0] q,
                        input bit lock, input logic [7:0] nm,
                        input logic [7:0] nq);
    int p;
    int beats;
    logic [15:0] prod;
    p = $signed(m) * $signed(q);
    prod = p[15:0];
    beats = 0;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (wb_enable) beats++;
      check($sformatf("busy k=%0d", k), busy, k <= 10);
      check($sformatf("wb_en k=%0d", k), wb_enable, k == 9 || k == 10);
      check($sformatf("done k=%0d", k), done, k == 10);
      if (k == 9) begin
        check("lo_beat", wb_data, prod[7:0]);
        check("lo_sel", wb_sel, 0);
      end else if (k == 10) begin
        check("hi_beat", wb_data, prod[15:8]);
        check("hi_sel", wb_sel, 1);
      end else begin
        check($sformatf("idle_data k=%0d", k), wb_data, 0);
      end
      if (lock) begin
        start  = 1'b1;
        mcand  = (k == 11) ? nm : 8'($urandom_range(0, 255));
        mplier = (k == 11) ? nq : 8'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
    end
    check("beat_count", beats, 2);
  endtask

  initial begin
    logic [7:0] am, aq, bm, bq;
    int seen;
    clear  = 1'b0;
    start  = 1'b1;
    mcand  = 8'd9;
    mplier = 8'd9;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wb_en", wb_enable, 0);
    check("rst_sel", wb_sel, 0);
    check("rst_data", wb_data, 0);
    start = 1'b0;
    @(negedge clk);
    clear = 1'b1;

    issue(8'd3, 8'd5);
    finish(8'd3, 8'd5, 0, 0, 0);
    issue(8'hF9, 8'd6);
    finish(8'hF9, 8'd6, 0, 0, 0);
    issue(8'h80, 8'h80);
    finish(8'h80, 8'h80, 0, 0, 0);
    issue(8'h7F, 8'h80);
    finish(8'h7F, 8'h80, 0, 0, 0);
    issue(8'h00, 8'hFF);
    finish(8'h00, 8'hFF, 0, 0, 0);

    issue(8'd11, 8'hF3);
    finish(8'd11, 8'hF3, 1, 8'd4, 8'd5);
    finish(8'd4, 8'd5, 0, 0, 0);

    issue(8'd2, 8'd3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wb_en", wb_enable, 0);
    check("mid_rst_sel", wb_sel, 0);
    check("mid_rst_data", wb_data, 0);
    @(negedge clk);
    clear = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (wb_enable || busy) seen++;
    end
    check("no_beat_after_rst", seen, 0);
    issue(8'd2, 8'd2);
    finish(8'd2, 8'd2, 0, 0, 0);

    am = 8'($urandom_range(0, 255));
    aq = 8'($urandom_range(0, 255));
    issue(am, aq);
    for (int i = 0; i < 10; i++) begin
      bm = 8'($urandom_range(0, 255));
      bq = 8'($urandom_range(0, 255));
      finish(am, aq, i < 9, bm, bq);
      am = bm;
      aq = bq;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
